alu_lbist_ctrl: RTL and testbench
=================================

Name: alu_lbist_ctrl

Overview:
- Logic-BIST sequencer for the 8-bit ALU (add/sub/and/or/xor/shl/shr/pass, 3-bit opcode).
- Replaces the fixed five-vector table with pseudo-random stimulus: a 16-bit LFSR drives operands, a pattern counter cycles the opcode, and an 8-bit MISR compacts every ALU result.
- The final signature is compared against a golden value.
- Sits beside the ALU; while active, its alu_sel output switches the ALU operand mux from functional to BIST sources.

Parameters:
- NUM_PATTERNS, 256, number of vectors applied per run; legal range 1..65535.
- LFSR_SEED, 16'hACE1, LFSR start value; a value of 0 is replaced internally by 16'h0001.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- bist_start  in  1  level; sampled only in IDLE.
- bist_abort  in  1  level; terminates a run in progress.
- golden_sig  in  8  expected MISR signature; sampled in COMPARE.
- alu_result  in  8  combinational ALU output.
- a  out  8  ALU operand a (registered).
- b  out  8  ALU operand b (registered).
- opcode  out  3  ALU opcode (registered).
- alu_sel  out  1  1 = ALU mux takes a/b/opcode from this block.
- bist_busy  out  1  high in INIT, RUN and COMPARE.
- bist_done  out  1  sticky completion flag.
- bist_pass  out  1  sticky; signature matched.
- bist_fail  out  1  sticky; mismatch or abort.
- signature  out  8  current MISR contents.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - a, b, opcode, signature = 0; LFSR = seed.
  - pattern counter = 0.
  - alu_sel, busy, done, pass, fail = 0.
- States: IDLE, INIT, RUN, COMPARE. Registered FSM with one next-state process; no latches.
- IDLE:
  - a, b, opcode held at 0; alu_sel=0.
  - bist_start=1 at an edge -> INIT.
- INIT (1 cycle):
  - Clear done/pass/fail; signature<=0; cnt<=0; LFSR<=seed.
  - a<=seed[15:8], b<=seed[7:0], opcode<=0.
  - alu_sel<=1, busy<=1 -> RUN.
- LFSR: Fibonacci, shift left, lfsr_next = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
- MISR: sig_next = {sig[6:0], sig[7]^sig[5]^sig[4]^sig[3]} ^ alu_result.
- RUN (one vector per cycle), each edge:
  - signature<=sig_next using the alu_result of the vector currently driven.
  - LFSR<=lfsr_next; a<=lfsr_next[15:8], b<=lfsr_next[7:0].
  - opcode<=(cnt+1)[2:0]; cnt<=cnt+1.
  - When cnt==NUM_PATTERNS-1 the absorption is the last one -> COMPARE; a/b/opcode update at that edge is don't-care.
- COMPARE (1 cycle):
  - pass<=(signature==golden_sig); fail<=!(signature==golden_sig); done<=1.
  - alu_sel<=0, busy<=0; a/b/opcode<=0 -> IDLE.
- Latency: start sampled at edge E0; done, pass and fail are visible after edge E0+NUM_PATTERNS+2.
- Flag stickiness:
  - done/pass/fail hold until the next INIT.
  - pass and fail are never both 1; done=0 implies pass=fail=0.
- bist_start handling:
  - Ignored outside IDLE.
  - If held high continuously, a new run starts on the cycle after returning to IDLE.
- bist_abort:
  - In INIT, RUN or COMPARE, abort wins over all other transitions -> IDLE.
  - Sets done=1, fail=1, pass=0, alu_sel=0, busy=0; a/b/opcode=0; signature frozen.
  - Ignored in IDLE.
  - If bist_abort and bist_start are both high in IDLE, start is taken.
- Counter width: $clog2(NUM_PATTERNS+1); no wrap before terminal count.
- NUM_PATTERNS=1: exactly one RUN cycle.
- Reset mid-run: immediate return to reset values; no flags preserved.

Test Plan:
- Reset, then start pulse with NUM_PATTERNS=8.
  - After INIT: a=8'hAC, b=8'hE1, opcode=0, alu_sel=1.
  - After the first RUN edge: a=8'h59, b=8'hC3, opcode=1.
  - busy high for exactly 10 cycles.
- Full run against a correct ALU, golden_sig taken from the bench reference model of LFSR/MISR/ALU:
  - done=1, pass=1, fail=0 exactly NUM_PATTERNS+2 edges after start.
  - signature equals the model value.
- Same run with golden_sig = model ^ 8'h01:
  - done=1, pass=0, fail=1.
  - Separately, inject a stuck-at-0 on alu_result[0] -> fail=1.
- Assert bist_abort in the 4th RUN cycle:
  - Next edge: state IDLE, done=1, fail=1, pass=0, alu_sel=0.
  - Signature unchanged from the value before the abort edge.
- bist_start toggled during RUN: no restart, and the pattern counter continues.
  - Then hold bist_start high: a second run starts one cycle after COMPARE, with flags cleared in INIT.
- Drop reset_n asynchronously mid-RUN (between edges):
  - All outputs go to 0 immediately.
  - After release, the block idles until bist_start; a subsequent run reproduces the same signature.

Source files
------------

// File: rtl/alu_lbist_ctrl.sv
// Logic-BIST sequencer for the 8-bit ALU: LFSR operands, cycling opcode,
// MISR compaction of ALU results and a final golden-signature compare.
module alu_lbist_ctrl #(
    parameter int unsigned NUM_PATTERNS = 256,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       bist_start,
    input  logic       bist_abort,
    input  logic [7:0] golden_sig,
    input  logic [7:0] alu_result,
    output logic [7:0] a,
    output logic [7:0] b,
    output logic [2:0] opcode,
    output logic       alu_sel,
    output logic       bist_busy,
    output logic       bist_done,
    output logic       bist_pass,
    output logic       bist_fail,
    output logic [7:0] signature
);

    localparam int unsigned  CW   = $clog2(NUM_PATTERNS + 1);
    localparam logic [15:0]  SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [CW-1:0] LAST = CW'(NUM_PATTERNS - 1);

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        RUN,
        COMPARE
    } state_t;

    state_t          state;
    state_t          state_d;
    logic [15:0]     lfsr;
    logic [15:0]     lfsr_next;
    logic [7:0]      sig_next;
    logic [CW-1:0]   cnt;
    logic            aborting;

    always_comb begin
        lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        sig_next  = {signature[6:0], signature[7] ^ signature[5] ^ signature[4] ^ signature[3]}
                    ^ alu_result;
    end

    always_comb begin
        state_d  = state;
        aborting = 1'b0;
        case (state)
            IDLE:    if (bist_start) state_d = INIT;
            INIT:    state_d = RUN;
            RUN:     if (cnt == LAST) state_d = COMPARE;
            COMPARE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state != IDLE && bist_abort) begin
            aborting = 1'b1;
            state_d  = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_d;
    end

    assign bist_busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a         <= '0;
            b         <= '0;
            opcode    <= '0;
            alu_sel   <= 1'b0;
            bist_done <= 1'b0;
            bist_pass <= 1'b0;
            bist_fail <= 1'b0;
            signature <= '0;
            lfsr      <= SEED;
            cnt       <= '0;
        end else if (aborting) begin
            a         <= '0;
            b         <= '0;
            opcode    <= '0;
            alu_sel   <= 1'b0;
            bist_done <= 1'b1;
            bist_pass <= 1'b0;
            bist_fail <= 1'b1;
        end else begin
            case (state)
                INIT: begin
                    bist_done <= 1'b0;
                    bist_pass <= 1'b0;
                    bist_fail <= 1'b0;
                    signature <= '0;
                    cnt       <= '0;
                    lfsr      <= SEED;
                    a         <= SEED[15:8];
                    b         <= SEED[7:0];
                    opcode    <= '0;
                    alu_sel   <= 1'b1;
                end
                RUN: begin
                    signature <= sig_next;
                    lfsr      <= lfsr_next;
                    a         <= lfsr_next[15:8];
                    b         <= lfsr_next[7:0];
                    // opcode always equals cnt[2:0], so incrementing it avoids
                    // slicing a counter that may be narrower than 3 bits
                    opcode    <= opcode + 3'd1;
                    cnt       <= cnt + CW'(1);
                end
                COMPARE: begin
                    bist_pass <= (signature == golden_sig);
                    bist_fail <= (signature != golden_sig);
                    bist_done <= 1'b1;
                    alu_sel   <= 1'b0;
                    a         <= '0;
                    b         <= '0;
                    opcode    <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_lbist_ctrl.sv
// Self-checking bench for alu_lbist_ctrl: scenario table plus hand sequences,
// checked against a loop-based LFSR/ALU/MISR reference model.
module tb_alu_lbist_ctrl;

    localparam int NP = 8;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       bist_start;
    logic       bist_abort;
    logic [7:0] golden_sig;
    logic [7:0] golden1;
    logic [7:0] alu_result;
    logic [7:0] alu_result1;
    logic       stuck;

    logic [7:0] a, b, signature;
    logic [2:0] opcode;
    logic       alu_sel, bist_busy, bist_done, bist_pass, bist_fail;
    logic [7:0] a1, b1, signature1;
    logic [2:0] opcode1;
    logic       alu_sel1, bist_busy1, bist_done1, bist_pass1, bist_fail1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_lbist_ctrl #(.NUM_PATTERNS(NP)) dut (
        .clk(clk), .reset_n(reset_n), .bist_start(bist_start), .bist_abort(bist_abort),
        .golden_sig(golden_sig), .alu_result(alu_result),
        .a(a), .b(b), .opcode(opcode), .alu_sel(alu_sel), .bist_busy(bist_busy),
        .bist_done(bist_done), .bist_pass(bist_pass), .bist_fail(bist_fail),
        .signature(signature)
    );

    alu_lbist_ctrl #(.NUM_PATTERNS(1), .LFSR_SEED(16'h0000)) dut1 (
        .clk(clk), .reset_n(reset_n), .bist_start(bist_start), .bist_abort(bist_abort),
        .golden_sig(golden1), .alu_result(alu_result1),
        .a(a1), .b(b1), .opcode(opcode1), .alu_sel(alu_sel1), .bist_busy(bist_busy1),
        .bist_done(bist_done1), .bist_pass(bist_pass1), .bist_fail(bist_fail1),
        .signature(signature1)
    );

    function automatic logic [7:0] alu_f(input logic [7:0] x, input logic [7:0] y,
                                         input logic [2:0] op);
        case (op)
            3'd0:    return x + y;
            3'd1:    return x - y;
            3'd2:    return x & y;
            3'd3:    return x | y;
            3'd4:    return x ^ y;
            3'd5:    return x << 1;
            3'd6:    return x >> 1;
            default: return x;
        endcase
    endfunction

    always_comb begin
        alu_result = alu_f(a, b, opcode);
        if (stuck) alu_result[0] = 1'b0;
        alu_result1 = alu_f(a1, b1, opcode1);
    end

    // Reference model: vector i uses the i-th LFSR state and opcode i mod 8
    function automatic logic [15:0] lfsr_at(input logic [15:0] seed, input int i);
        logic [15:0] l;
        l = (seed == 16'h0000) ? 16'h0001 : seed;
        for (int k = 0; k < i; k++) l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        return l;
    endfunction

    function automatic logic [7:0] model_sig(input logic [15:0] seed, input int nabs,
                                             input bit stk);
        logic [7:0]  s;
        logic [7:0]  r;
        logic [15:0] l;
        s = 8'h00;
        for (int i = 0; i < nabs; i++) begin
            l = lfsr_at(seed, i);
            r = alu_f(l[15:8], l[7:0], 3'(i % 8));
            if (stk) r[0] = 1'b0;
            s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]} ^ r;
        end
        return s;
    endfunction

    typedef struct {
        logic [7:0] flip;
        bit         stk;
        int         abort_k;
        bit         toggle;
        logic [7:0] golden;
        logic [7:0] exp_sig;
        bit         exp_pass;
        bit         exp_fail;
    } vec_t;

    vec_t       tbl[9];
    logic [7:0] good_sig;

    function automatic vec_t mk(input logic [7:0] flip, input bit stk, input int abort_k,
                                input bit toggle);
        vec_t v;
        v.flip    = flip;
        v.stk     = stk;
        v.abort_k = abort_k;
        v.toggle  = toggle;
        v.golden  = good_sig ^ flip;
        if (abort_k > 0) begin
            v.exp_sig  = model_sig(16'hACE1, abort_k - 1, stk);
            v.exp_pass = 1'b0;
            v.exp_fail = 1'b1;
        end else begin
            v.exp_sig  = model_sig(16'hACE1, NP, stk);
            v.exp_pass = (v.exp_sig == v.golden);
            v.exp_fail = !v.exp_pass;
        end
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        int         n;
        int         busy_cyc;
        bit         ended;
        logic [7:0] sig_before;
        logic [15:0] l;
        golden_sig = v.golden;
        stuck      = v.stk;
        sig_before = 8'h00;
        bist_start = 1'b1;
        tick();
        bist_start = 1'b0;
        n        = 0;
        ended    = 1'b0;
        busy_cyc = 32'(bist_busy);
        check("busy_in_init", 32'(bist_busy), 1);
        while (!ended && n < NP + 10) begin
            if (v.toggle && (n == 3 || n == 5)) bist_start = 1'b1;
            if (v.abort_k > 0 && n == v.abort_k) begin
                bist_abort = 1'b1;
                sig_before = signature;
            end
            tick();
            n++;
            bist_start = 1'b0;
            bist_abort = 1'b0;
            if (bist_busy) busy_cyc++;
            if (n == 1) begin
                check("flags_cleared", 32'({bist_done, bist_pass, bist_fail}), 0);
                check("init_a", 32'(a), 32'h00AC);
                check("init_b", 32'(b), 32'h00E1);
            end
            if (n == 2) begin
                check("run1_a", 32'(a), 32'h0059);
                check("run1_b", 32'(b), 32'h00C3);
            end
            if (n >= 1 && n <= NP && bist_busy) begin
                l = lfsr_at(16'hACE1, n - 1);
                check("vec_ab", 32'({a, b}), 32'(l));
                check("vec_op", 32'(opcode), 32'((n - 1) % 8));
                check("vec_sel", 32'(alu_sel), 1);
                check("vec_sig", 32'(signature), 32'(model_sig(16'hACE1, n - 1, v.stk)));
            end
            if (!bist_busy) ended = 1'b1;
        end
        check("run_end", 32'(ended), 1);
        if (v.abort_k > 0) begin
            check("abort_edge", n, v.abort_k + 1);
            check("abort_sig_frozen", 32'(signature), 32'(sig_before));
        end else begin
            check("done_latency", n, NP + 2);
            check("busy_cycles", busy_cyc, NP + 2);
        end
        check("done", 32'(bist_done), 1);
        check("pass", 32'(bist_pass), 32'(v.exp_pass));
        check("fail", 32'(bist_fail), 32'(v.exp_fail));
        check("sel_off", 32'(alu_sel), 0);
        check("ops_zero", 32'({a, b, opcode}), 0);
        check("signature", 32'(signature), 32'(v.exp_sig));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  ended;
        reset_n    = 1'b0;
        bist_start = 1'b0;
        bist_abort = 1'b0;
        stuck      = 1'b0;
        good_sig   = model_sig(16'hACE1, NP, 1'b0);
        golden_sig = good_sig;
        golden1    = model_sig(16'h0000, 1, 1'b0);

        tbl[0] = mk(8'h00, 1'b0, 0, 1'b0);
        tbl[1] = mk(8'h01, 1'b0, 0, 1'b0);
        tbl[2] = mk(8'h00, 1'b1, 0, 1'b0);
        tbl[3] = mk(8'h00, 1'b0, 4, 1'b0);
        tbl[4] = mk(8'h00, 1'b0, 0, 1'b1);
        for (int i = 5; i < 9; i++)
            tbl[i] = mk(($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(1, 255)),
                        1'($urandom_range(0, 1)),
                        ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, NP + 1)) : 0,
                        1'($urandom_range(0, 1)));

        tick();
        tick();
        check("reset_outs", 32'({a, b, opcode, alu_sel, bist_busy, bist_done, bist_pass,
                                 bist_fail, signature}), 0);
        #2 reset_n = 1'b1;
        tick();
        check("idle_busy", 32'(bist_busy), 0);

        // single-pattern instance with zero seed runs alongside the main DUT
        bist_start = 1'b1;
        tick();
        bist_start = 1'b0;
        check("np1_busy_init", 32'(bist_busy1), 1);
        tick();
        check("np1_seed_sub", 32'({a1, b1}), 32'h0001);
        tick();
        check("np1_busy_cmp", 32'(bist_busy1), 1);
        tick();
        check("np1_busy_off", 32'(bist_busy1), 0);
        check("np1_flags", 32'({bist_done1, bist_pass1, bist_fail1}), 32'b110);
        check("np1_sig", 32'(signature1), 32'(golden1));
        n = 0;
        while (bist_busy && n < NP + 10) begin
            tick();
            n++;
        end
        check("warmup_end", 32'(bist_busy), 0);

        for (int i = 0; i < 9; i++) run_vec(tbl[i]);

        // start held high across completion: immediate restart with flags cleared
        stuck      = 1'b0;
        golden_sig = good_sig;
        bist_start = 1'b1;
        tick();
        n = 0;
        while (bist_busy && n < NP + 10) begin
            tick();
            n++;
        end
        check("hold_latency", n, NP + 2);
        check("hold_pass1", 32'({bist_done, bist_pass, bist_fail}), 32'b110);
        tick();
        check("hold_restart", 32'(bist_busy), 1);
        check("hold_flags_kept", 32'(bist_done), 1);
        tick();
        bist_start = 1'b0;
        check("hold_flags_cleared", 32'({bist_done, bist_pass, bist_fail}), 0);
        check("hold_a", 32'(a), 32'h00AC);
        n = 0;
        while (bist_busy && n < NP + 10) begin
            tick();
            n++;
        end
        check("hold_pass2", 32'({bist_busy, bist_done, bist_pass, bist_fail}), 32'b0110);

        // asynchronous reset in the middle of a run
        bist_start = 1'b1;
        tick();
        bist_start = 1'b0;
        tick();
        tick();
        tick();
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_outs", 32'({a, b, opcode, alu_sel, bist_busy, bist_done, bist_pass,
                                       bist_fail, signature}), 0);
        #3 reset_n = 1'b1;
        ended = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bist_busy || alu_sel) ended = 1'b0;
        end
        check("post_reset_idle", 32'(ended), 1);
        run_vec(tbl[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
